// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable serial receiver: 5..9 data bits LSB first, none/odd/even parity, 1 or 2 stop bits.
// Latency: rx_dv_out pulses 2 + H + (frame_bits-1)*clk_per_bit + 1 clk after the start edge, H = (clk_per_bit-1)/2.
// Backpressure: none; rx_out and both error flags hold their values until the next completed frame.
//
// Ports:
//   clk, rst           system clock (rising edge), asynchronous active-high reset
//   rx_serial_in       raw serial line, idles high, asynchronous to clk
//   rx_dv_out          one-cycle pulse when a frame completes (also for frames with errors)
//   rx_out             received data word, updated together with rx_dv_out
//   rx_parity_err_out  parity mismatch on the last completed frame
//   rx_frame_err_out   a stop bit was sampled low on the last completed frame
//   rx_busy_out        high whenever the receiver is not idle
module uart_rx_cfg #(
   parameter int clk_per_bit = 87,
   parameter int data_bits   = 8,
   parameter int parity_mode = 0,
   parameter int stop_bits   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_serial_in,
   output logic                 rx_dv_out,
   output logic [data_bits-1:0] rx_out,
   output logic                 rx_parity_err_out,
   output logic                 rx_frame_err_out,
   output logic                 rx_busy_out
);

   localparam int CW = $clog2(clk_per_bit);
   localparam int BW = $clog2(data_bits);

   // The IDLE cycle that first sees rs low counts as the first cycle of the
   // half-bit wait, so START compares against H-1 to land the sample at t0+H.
   localparam logic [CW-1:0] HALF_M1   = CW'((clk_per_bit - 1) / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(clk_per_bit - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(data_bits - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE,
      WAIT_HIGH
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 rs_meta;
   logic                 rs;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_idx;
   logic [data_bits-1:0] shift_reg;
   logic                 par_bit;
   logic                 stop_err;
   logic                 half_hit;
   logic                 bit_hit;
   logic                 par_err;

   // Two-flop synchroniser; both stages reset to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_meta <= 1'b1;
         rs      <= 1'b1;
      end else begin
         rs_meta <= rx_serial_in;
         rs      <= rs_meta;
      end
   end

   assign half_hit = (clk_cnt == HALF_M1);
   assign bit_hit  = (clk_cnt == BIT_LAST);

   // Parity check against the received data word and parity bit.
   always_comb begin
      par_err = 1'b0;
      if (parity_mode == 1) begin
         par_err = ~(^shift_reg ^ par_bit);
      end else if (parity_mode == 2) begin
         par_err = ^shift_reg ^ par_bit;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rs) state_nxt = START;
         end
         START: begin
            // A line that is high again at mid start bit was a glitch.
            if (half_hit) state_nxt = rs ? IDLE : DATA;
         end
         DATA: begin
            if (bit_hit && (bit_idx == DATA_LAST)) begin
               state_nxt = (parity_mode != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_hit) state_nxt = STOP;
         end
         STOP: begin
            if (bit_hit && (bit_idx == STOP_LAST)) state_nxt = DONE;
         end
         DONE: begin
            // A line still low here is a break; wait for it to release so a
            // held-low line produces only the one frame-error frame.
            state_nxt = rs ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (rs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      rx_dv_out   = (state == DONE);
      rx_busy_out = (state != IDLE);
   end

   // Bit timing, shift register and output registers. The output word and
   // flags are written on the last stop sample so they are valid during DONE,
   // the same cycle rx_dv_out is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt           <= '0;
         bit_idx           <= '0;
         shift_reg         <= '0;
         par_bit           <= 1'b0;
         stop_err          <= 1'b0;
         rx_out            <= '0;
         rx_parity_err_out <= 1'b0;
         rx_frame_err_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clk_cnt  <= '0;
               bit_idx  <= '0;
               stop_err <= 1'b0;
            end
            START: begin
               clk_cnt  <= half_hit ? '0 : clk_cnt + 1'b1;
               bit_idx  <= '0;
               stop_err <= 1'b0;
            end
            DATA: begin
               if (bit_hit) begin
                  clk_cnt   <= '0;
                  shift_reg <= {rs, shift_reg[data_bits-1:1]};
                  bit_idx   <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_hit) begin
                  clk_cnt <= '0;
                  par_bit <= rs;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_hit) begin
                  clk_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     rx_out            <= shift_reg;
                     rx_parity_err_out <= par_err;
                     rx_frame_err_out  <= stop_err | ~rs;
                     bit_idx           <= '0;
                  end else begin
                     stop_err <= stop_err | ~rs;
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               clk_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed frames into three receiver instances (8N1, 8E1, 7N2).
// Expected words/flags come from a frame-level model: bit list built from data, parity rule and stop values.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int CPB0 = 87;
   localparam int CPB1 = 16;
   localparam int CPB2 = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;
   logic       dv0, pe0, fe0, busy0;
   logic       dv1, pe1, fe1, busy1;
   logic       dv2, pe2, fe2, busy2;
   logic [7:0] out0, out1;
   logic [6:0] out2;

   int cyc = 0;
   int n_pass = 0;
   int n_checks = 0;

   typedef struct {
      logic [8:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } ev_t;

   ev_t q0[$], q1[$], q2[$];

   uart_rx_cfg #(.clk_per_bit(CPB0), .data_bits(8), .parity_mode(0), .stop_bits(1)) u_8n1 (
      .clk(clk), .rst(rst), .rx_serial_in(ser0), .rx_dv_out(dv0), .rx_out(out0),
      .rx_parity_err_out(pe0), .rx_frame_err_out(fe0), .rx_busy_out(busy0));

   uart_rx_cfg #(.clk_per_bit(CPB1), .data_bits(8), .parity_mode(2), .stop_bits(1)) u_8e1 (
      .clk(clk), .rst(rst), .rx_serial_in(ser1), .rx_dv_out(dv1), .rx_out(out1),
      .rx_parity_err_out(pe1), .rx_frame_err_out(fe1), .rx_busy_out(busy1));

   uart_rx_cfg #(.clk_per_bit(CPB2), .data_bits(7), .parity_mode(0), .stop_bits(2)) u_7n2 (
      .clk(clk), .rst(rst), .rx_serial_in(ser2), .rx_dv_out(dv2), .rx_out(out2),
      .rx_parity_err_out(pe2), .rx_frame_err_out(fe2), .rx_busy_out(busy2));

   always #50 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every completed frame seen on each instance.
   always @(negedge clk) begin
      if (dv0 === 1'b1) q0.push_back('{d: {1'b0, out0}, pe: pe0, fe: fe0, cyc: cyc});
      if (dv1 === 1'b1) q1.push_back('{d: {1'b0, out1}, pe: pe1, fe: fe1, cyc: cyc});
      if (dv2 === 1'b1) q2.push_back('{d: {2'b00, out2}, pe: pe2, fe: fe2, cyc: cyc});
   end

   // ---------------- reference model ----------------
   // Line bits of one frame, index 0 sent first.
   function automatic logic [15:0] build_frame(input logic [8:0] d, input int nd, input int pm,
                                               input int ns, input logic bad_par, input logic [1:0] stops);
      logic [15:0] b;
      int          pos;
      int          ones;
      logic        p;
      b    = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < nd; i++) begin
         b[1 + i] = d[i];
         if (d[i]) ones = ones + 1;
      end
      pos = 1 + nd;
      if (pm != 0) begin
         // odd: total ones in data+parity is odd; even: total is even
         if (pm == 1) p = (ones % 2 == 0);
         else         p = (ones % 2 == 1);
         b[pos] = p ^ bad_par;
         pos    = pos + 1;
      end
      b[pos] = stops[0];
      if (ns == 2) b[pos + 1] = stops[1];
      return b;
   endfunction

   function automatic int frame_len(input int nd, input int pm, input int ns);
      return 1 + nd + ((pm != 0) ? 1 : 0) + ns;
   endfunction

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int k, input logic v);
      case (k)
         0:       ser0 = v;
         1:       ser1 = v;
         default: ser2 = v;
      endcase
   endtask

   task automatic send_frame(input int k, input int cpb, input logic [15:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         drive_line(k, b[i]);
         repeat (cpb) step();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({dv0, out0, pe0, fe0, busy0} !== 12'h000)
         $display("FAIL reset_8n1: got %h want 000", {dv0, out0, pe0, fe0, busy0});
      else n_pass++;
      n_checks++;
      if ({dv1, out1, pe1, fe1, busy1} !== 12'h000)
         $display("FAIL reset_8e1: got %h want 000", {dv1, out1, pe1, fe1, busy1});
      else n_pass++;
      n_checks++;
      if ({dv2, out2, pe2, fe2, busy2} !== 11'h000)
         $display("FAIL reset_7n2: got %h want 000", {dv2, out2, pe2, fe2, busy2});
      else n_pass++;
      rst = 1'b0;
      repeat (10) step();
      n_checks++;
      if ({busy0, busy1, busy2, dv0, dv1, dv2} !== 6'b0)
         $display("FAIL reset_idle: got %b want 000000", {busy0, busy1, busy2, dv0, dv1, dv2});
      else n_pass++;
   endtask

   task automatic test_basic_8n1();
      int  c0;
      int  lat;
      int  exp_lat;
      ev_t g;
      exp_lat = 2 + (CPB0 - 1) / 2 + 9 * CPB0 + 1;
      c0 = cyc;
      send_frame(0, CPB0, build_frame(9'h03F, 8, 0, 1, 1'b0, 2'b11), frame_len(8, 0, 1));
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== 1) $display("FAIL basic_count: got %0d want 1", q0.size());
      else n_pass++;
      if (q0.size() > 0) begin
         g = q0.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {9'h03F, 1'b0, 1'b0})
            $display("FAIL basic_data: got d=%h pe=%b fe=%b want d=03f pe=0 fe=0", g.d, g.pe, g.fe);
         else n_pass++;
         lat = g.cyc - c0;
         n_checks++;
         if (lat < exp_lat - 1 || lat > exp_lat + 1)
            $display("FAIL basic_latency: got %0d want %0d +-1", lat, exp_lat);
         else n_pass++;
      end
      q0.delete();
   endtask

   task automatic test_back_to_back_8n1();
      ev_t        exp_q[$];
      ev_t        e, g;
      logic [8:0] d;
      for (int i = 0; i < 5; i++) begin
         d = 9'($urandom_range(0, 255));
         exp_q.push_back('{d: d, pe: 1'b0, fe: 1'b0, cyc: 0});
         send_frame(0, CPB0, build_frame(d, 8, 0, 1, 1'b0, 2'b11), frame_len(8, 0, 1));
         repeat ($urandom_range(0, 1) * $urandom_range(1, 20)) step();
      end
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== exp_q.size()) $display("FAIL b2b_8n1_count: got %0d want %0d", q0.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && q0.size() > 0) begin
         e = exp_q.pop_front();
         g = q0.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {e.d, e.pe, e.fe})
            $display("FAIL b2b_8n1_frame: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
         else n_pass++;
      end
      q0.delete();
   endtask

   task automatic test_glitch();
      int hi_seen;
      int done_at;
      hi_seen = 0;
      done_at = -1;
      ser0 = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         step();
         if (n == 20) ser0 = 1'b1;
         if (busy0) hi_seen = 1;
         else if (hi_seen != 0 && done_at < 0) done_at = n;
      end
      n_checks++;
      if (done_at < 1 || done_at > 46) $display("FAIL glitch_busy: got release at cycle %0d want 1..46", done_at);
      else n_pass++;
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== 0) $display("FAIL glitch_no_dv: got %0d pulses want 0", q0.size());
      else n_pass++;
      q0.delete();
   endtask

   task automatic test_framing_break();
      ev_t g;
      // Bad stop bit, then the line stays low for 30 bit periods.
      send_frame(0, CPB0, build_frame(9'h055, 8, 0, 1, 1'b0, 2'b00), frame_len(8, 0, 1));
      repeat (30 * CPB0) step();
      ser0 = 1'b1;
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== 1) $display("FAIL break_count: got %0d want 1", q0.size());
      else n_pass++;
      if (q0.size() > 0) begin
         g = q0.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {9'h055, 1'b0, 1'b1})
            $display("FAIL break_frame: got d=%h pe=%b fe=%b want d=055 pe=0 fe=1", g.d, g.pe, g.fe);
         else n_pass++;
      end
      n_checks++;
      if ({out0, fe0} !== {8'h55, 1'b1}) $display("FAIL break_hold: got out=%h fe=%b want out=55 fe=1", out0, fe0);
      else n_pass++;
      q0.delete();
      send_frame(0, CPB0, build_frame(9'h0C3, 8, 0, 1, 1'b0, 2'b11), frame_len(8, 0, 1));
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== 1) $display("FAIL after_break_count: got %0d want 1", q0.size());
      else n_pass++;
      if (q0.size() > 0) begin
         g = q0.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {9'h0C3, 1'b0, 1'b0})
            $display("FAIL after_break_frame: got d=%h pe=%b fe=%b want d=0c3 pe=0 fe=0", g.d, g.pe, g.fe);
         else n_pass++;
      end
      q0.delete();
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] b;
      ev_t         g;
      b = build_frame(9'h081, 8, 0, 1, 1'b0, 2'b11);
      // start bit plus data bits 0..2, then part of data bit 3
      send_frame(0, CPB0, b, 4);
      ser0 = b[4];
      repeat (40) step();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({dv0, out0, pe0, fe0, busy0} !== 12'h000)
         $display("FAIL midreset_outputs: got %h want 000", {dv0, out0, pe0, fe0, busy0});
      else n_pass++;
      ser0 = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (12 * CPB0) step();
      n_checks++;
      if (q0.size() !== 0) $display("FAIL midreset_no_dv: got %0d pulses want 0", q0.size());
      else n_pass++;
      q0.delete();
      send_frame(0, CPB0, b, frame_len(8, 0, 1));
      repeat (2 * CPB0) step();
      n_checks++;
      if (q0.size() !== 1) $display("FAIL midreset_resend_count: got %0d want 1", q0.size());
      else n_pass++;
      if (q0.size() > 0) begin
         g = q0.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {9'h081, 1'b0, 1'b0})
            $display("FAIL midreset_resend: got d=%h pe=%b fe=%b want d=081 pe=0 fe=0", g.d, g.pe, g.fe);
         else n_pass++;
      end
      q0.delete();
   endtask

   task automatic test_parity_8e1();
      ev_t        exp_q[$];
      ev_t        e, g;
      logic [8:0] d;
      logic       bad;
      // directed: 0xA5 with correct parity (0), then with wrong parity (1)
      exp_q.push_back('{d: 9'h0A5, pe: 1'b0, fe: 1'b0, cyc: 0});
      send_frame(1, CPB1, build_frame(9'h0A5, 8, 2, 1, 1'b0, 2'b11), frame_len(8, 2, 1));
      repeat (3) step();
      exp_q.push_back('{d: 9'h0A5, pe: 1'b1, fe: 1'b0, cyc: 0});
      send_frame(1, CPB1, build_frame(9'h0A5, 8, 2, 1, 1'b1, 2'b11), frame_len(8, 2, 1));
      repeat (3) step();
      for (int i = 0; i < 8; i++) begin
         d   = 9'($urandom_range(0, 255));
         bad = 1'($urandom_range(0, 1));
         exp_q.push_back('{d: d, pe: bad, fe: 1'b0, cyc: 0});
         send_frame(1, CPB1, build_frame(d, 8, 2, 1, bad, 2'b11), frame_len(8, 2, 1));
         repeat ($urandom_range(0, 5)) step();
      end
      repeat (2 * CPB1) step();
      n_checks++;
      if (q1.size() !== exp_q.size()) $display("FAIL par8e1_count: got %0d want %0d", q1.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && q1.size() > 0) begin
         e = exp_q.pop_front();
         g = q1.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {e.d, e.pe, e.fe})
            $display("FAIL par8e1_frame: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
         else n_pass++;
      end
      q1.delete();
   endtask

   task automatic test_7n2();
      ev_t        exp_q[$];
      ev_t        e, g;
      logic [8:0] d;
      exp_q.push_back('{d: 9'h05A, pe: 1'b0, fe: 1'b0, cyc: 0});
      send_frame(2, CPB2, build_frame(9'h05A, 7, 0, 2, 1'b0, 2'b11), frame_len(7, 0, 2));
      repeat (2 * CPB2) step();
      // second stop bit low
      exp_q.push_back('{d: 9'h05A, pe: 1'b0, fe: 1'b1, cyc: 0});
      send_frame(2, CPB2, build_frame(9'h05A, 7, 0, 2, 1'b0, 2'b01), frame_len(7, 0, 2));
      ser2 = 1'b1;
      repeat (2 * CPB2) step();
      // back-to-back frames with no idle gap
      for (int i = 0; i < 3; i++) begin
         d = 9'($urandom_range(0, 127));
         exp_q.push_back('{d: d, pe: 1'b0, fe: 1'b0, cyc: 0});
         send_frame(2, CPB2, build_frame(d, 7, 0, 2, 1'b0, 2'b11), frame_len(7, 0, 2));
      end
      repeat (2 * CPB2) step();
      n_checks++;
      if (q2.size() !== exp_q.size()) $display("FAIL 7n2_count: got %0d want %0d", q2.size(), exp_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && q2.size() > 0) begin
         e = exp_q.pop_front();
         g = q2.pop_front();
         n_checks++;
         if ({g.d, g.pe, g.fe} !== {e.d, e.pe, e.fe})
            $display("FAIL 7n2_frame: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
         else n_pass++;
      end
      q2.delete();
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_back_to_back_8n1();
      test_glitch();
      test_framing_break();
      test_reset_mid_frame();
      test_parity_8e1();
      test_7n2();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
